adc_conv_ctrl: RTL
==================

// Module: adc_conv_ctrl
// PURPOSE
//  Digital initiator for the SAR ADC macro. Builds the ADC config words, issues the
//  start_conversion pulse train for the selected oversampling ratio (OSR), and waits
//  for conversion_finished. It then captures the 16-bit result and hands it to the
//  user-area logic over a valid/ready interface. Sits in the digital user area,
//  between the register/bus logic and the adc_top hard macro.
// PARAMETERS
//  START_HI   4     cycles start_conversion is held high per pulse (>=1)
//  START_LO   4     cycles start_conversion is held low between pulses (>=2)
//  TIMEOUT    4096  cycles to wait for finished after the last pulse before aborting
//  PERIOD_W   16    width of continuous-mode sample period counter
// PORTS
//  clk               in   1   system clock
//  rst_n             in   1   reset, asynchronous, active-low
//  enable            in   1   block enable; low forces IDLE
//  trigger           in   1   single-cycle request for one conversion
//  continuous        in   1   1 = auto-start every sample_period cycles
//  sample_period     in   PERIOD_W  continuous-mode period in clk cycles
//  osr_sel           in   3   0..4 -> OSR 1/4/16/64/256; 5..7 clamped to 4
//  delay_sel         in   5   SAR delay code, one of 1/2/4/8/16
//  delay_edge        in   6   edge delay code, passed to config_1[15:10]
//  clr_err           in   1   clears sticky error flags
//  adc_start_conv    out  1   to adc_top.start_conversion_in
//  adc_config_1      out  16  to adc_top.config_1_in
//  adc_config_2      out  16  to adc_top.config_2_in
//  adc_result        in   16  from adc_top.result_out (async domain)
//  adc_finished      in   1   from adc_top.conversion_finished_out (async domain)
//  data              out  16  captured conversion result
//  data_valid        out  1   data holds a result not yet consumed
//  data_ready        in   1   consumer accepts data when valid&&ready
//  busy              out  1   state != IDLE
//  timeout_err       out  1   sticky: finished never seen within TIMEOUT
//  overrun_err       out  1   sticky: result arrived while data_valid still high
// BEHAVIOUR
//  Reset: all outputs 0, except adc_config_2 = 16'h8000|{3{delay}} with delay=1 (16'h8421).
//  Config: latched on leaving IDLE and held constant for the whole conversion.
//   config_1 = {delay_edge,4'b0,osr,3'b0}. config_2 = {1'b1,delay_sel,delay_sel,delay_sel}.
//   A delay_sel of 0 or a value that is not a power of two is replaced by 5'd1.
//  adc_finished: 2-FF synchronised; the rising edge of the synchronised signal is used.
//  FSM: IDLE -> START_HI -> START_LO -> (pulse count < N ? START_HI : WAIT_DONE).
//   WAIT_DONE -> CAPTURE on sync rising edge; CAPTURE -> IDLE after 1 cycle.
//   N = 4^osr (1,4,16,64,256); 9-bit pulse counter, reset in IDLE.
//  adc_start_conv is registered: high exactly in START_HI (START_HI cycles per pulse).
//  WAIT_DONE: counter runs from 0. At TIMEOUT without an edge -> set timeout_err -> IDLE.
//   No data is produced in that case.
//  CAPTURE: adc_result sampled (stable, >=2 cycles after finished) into data.
//   If data_valid==0: data updated, data_valid=1 next cycle.
//   If data_valid==1 and not accepted this cycle: new result dropped, overrun_err set.
//  Handshake: data_valid falls the cycle after valid&&ready. Capture while valid&&ready
//   in the same cycle: the transfer completes, new data is loaded, valid stays 1.
//  Start sources, sampled only in IDLE with enable=1:
//   - trigger pulse.
//   - continuous period tick: counter counts 0..sample_period-1, runs while continuous&&enable,
//     and restarts at each tick. sample_period=0 is treated as 1.
//   Simultaneous trigger + tick -> one conversion. Trigger or tick while busy -> ignored.
//  enable low mid-conversion: IDLE next cycle, adc_start_conv low, no capture.
//   Data and flags are kept.
//  Async reset mid-conversion: everything returns to reset values immediately.
//  clr_err clears both flags. If a set and a clear occur in the same cycle, the set wins.
// TESTING
//  osr_sel=0, delay_sel=4, trigger -> 1 start pulse of 4 cycles, config_1=16'h0000,
//   config_2=16'h9084; model finishes -> data=result, valid held until ready.
//  osr_sel=2, trigger -> exactly 16 start pulses, then capture. Busy throughout, IDLE after.
//  Finished tied low, osr_sel=0 -> timeout_err=1 after 4096 cycles in WAIT_DONE;
//   valid stays 0; clr_err clears the flag.
//  continuous=1, sample_period=2000, data_ready=0 -> first result valid;
//   second result dropped with overrun_err=1; data is unchanged.
//  enable dropped at pulse 3 of 16 -> start low next cycle, IDLE, no capture.
//   Re-trigger -> full 16 pulses.
//  rst_n asserted in WAIT_DONE -> all outputs reset asynchronously; no spurious valid after release.

Source files
------------

// File: rtl/adc_conv_ctrl.sv
// SAR ADC conversion initiator: builds config words, emits the start pulse train
// for the selected OSR, waits for the synchronised finish edge and hands the result off.
//
// state   | meaning
// S_IDLE  | waiting for trigger or continuous tick
// S_HI    | start_conversion high, pulse width timer running
// S_LO    | start_conversion low, gap timer running
// S_WAIT  | all pulses sent, waiting for finished edge or timeout
// S_CAPT  | one cycle to sample the result into the output register
module adc_conv_ctrl #(
    parameter int START_HI = 4,
    parameter int START_LO = 4,
    parameter int TIMEOUT  = 4096,
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                trigger,
    input  logic                continuous,
    input  logic [PERIOD_W-1:0] sample_period,
    input  logic [2:0]          osr_sel,
    input  logic [4:0]          delay_sel,
    input  logic [5:0]          delay_edge,
    input  logic                clr_err,
    output logic                adc_start_conv,
    output logic [15:0]         adc_config_1,
    output logic [15:0]         adc_config_2,
    input  logic [15:0]         adc_result,
    input  logic                adc_finished,
    output logic [15:0]         data,
    output logic                data_valid,
    input  logic                data_ready,
    output logic                busy,
    output logic                timeout_err,
    output logic                overrun_err
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_HI, S_LO, S_WAIT, S_CAPT} state_t;

    state_t              state;
    logic [TMR_W-1:0]    tmr;
    logic [8:0]          pulse_cnt;
    logic [8:0]          pulse_target;
    logic [2:0]          osr_eff;
    logic                delay_ok;
    logic [4:0]          delay_eff;
    logic                fin_s1, fin_s2, fin_s3;
    logic                fin_rise;
    logic [PERIOD_W-1:0] per_cnt;
    logic [PERIOD_W-1:0] per_last;
    logic                per_run;
    logic                per_tick;
    logic                accept;
    logic                cap_now;
    logic                to_now;

    always_comb begin
        osr_eff   = (osr_sel > 3'd4) ? 3'd4 : osr_sel;
        delay_ok  = (delay_sel == 5'd1) || (delay_sel == 5'd2) || (delay_sel == 5'd4) ||
                    (delay_sel == 5'd8) || (delay_sel == 5'd16);
        delay_eff = delay_ok ? delay_sel : 5'd1;
        per_last  = (sample_period == '0) ? '0 : sample_period - PERIOD_W'(1);
        per_run   = continuous && enable;
        per_tick  = per_run && (per_cnt >= per_last);
        fin_rise  = fin_s2 && !fin_s3;
        accept    = data_valid && data_ready;
        cap_now   = enable && (state == S_CAPT);
        to_now    = enable && (state == S_WAIT) && !fin_rise && (tmr == '0);
    end

    // adc_finished comes from the macro's own timing domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fin_s1 <= 1'b0;
            fin_s2 <= 1'b0;
            fin_s3 <= 1'b0;
        end else begin
            fin_s1 <= adc_finished;
            fin_s2 <= fin_s1;
            fin_s3 <= fin_s2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            per_cnt <= '0;
        else if (!per_run || per_tick)
            per_cnt <= '0;
        else
            per_cnt <= per_cnt + PERIOD_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            adc_start_conv <= 1'b0;
            busy           <= 1'b0;
            tmr            <= '0;
            pulse_cnt      <= '0;
            pulse_target   <= 9'd1;
            adc_config_1   <= '0;
            adc_config_2   <= {1'b1, 5'd1, 5'd1, 5'd1};
        end else if (!enable) begin
            state          <= S_IDLE;
            adc_start_conv <= 1'b0;
            busy           <= 1'b0;
            pulse_cnt      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    pulse_cnt <= '0;
                    if (trigger || per_tick) begin
                        state          <= S_HI;
                        adc_start_conv <= 1'b1;
                        busy           <= 1'b1;
                        tmr            <= TMR_W'(START_HI - 1);
                        pulse_target   <= 9'd1 << {osr_eff, 1'b0};
                        adc_config_1   <= {delay_edge, 4'b0, osr_eff, 3'b0};
                        adc_config_2   <= {1'b1, delay_eff, delay_eff, delay_eff};
                    end
                end
                S_HI: begin
                    if (tmr == '0) begin
                        state          <= S_LO;
                        adc_start_conv <= 1'b0;
                        tmr            <= TMR_W'(START_LO - 1);
                        pulse_cnt      <= pulse_cnt + 9'd1;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                S_LO: begin
                    if (tmr == '0) begin
                        if (pulse_cnt < pulse_target) begin
                            state          <= S_HI;
                            adc_start_conv <= 1'b1;
                            tmr            <= TMR_W'(START_HI - 1);
                        end else begin
                            state <= S_WAIT;
                            tmr   <= TMR_W'(TIMEOUT - 1);
                        end
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                S_WAIT: begin
                    if (fin_rise) begin
                        state <= S_CAPT;
                    end else if (tmr == '0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                S_CAPT: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state          <= S_IDLE;
                    adc_start_conv <= 1'b0;
                    busy           <= 1'b0;
                end
            endcase
        end
    end

    // result has been stable for at least two cycles by the time we sit in S_CAPT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data        <= '0;
            data_valid  <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (cap_now && (!data_valid || accept)) begin
                data       <= adc_result;
                data_valid <= 1'b1;
            end else if (accept) begin
                data_valid <= 1'b0;
            end

            if (to_now)
                timeout_err <= 1'b1;
            else if (clr_err)
                timeout_err <= 1'b0;

            if (cap_now && data_valid && !accept)
                overrun_err <= 1'b1;
            else if (clr_err)
                overrun_err <= 1'b0;
        end
    end

endmodule
